// File: rtl/float_pkg.sv
// ============================================================================
// Module : float_pkg
// Brief  : Shared binary64 field layout, FSM states and done-reason codes.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package float_pkg;

   localparam int EXP_W   = 11;
   localparam int FRAC_W  = 52;
   localparam int EXP_MAX = 2047;

   typedef struct packed {
      logic              sign;
      logic [EXP_W-1:0]  exp;
      logic [FRAC_W-1:0] frac;
   } f64_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   typedef enum logic [2:0] {
      DR_NONE     = 3'd0,
      DR_OVERFLOW = 3'd1,
      DR_SPECIAL  = 3'd2,
      DR_ZERO     = 3'd3,
      DR_LIMIT    = 3'd4
   } done_reason_t;

   function automatic logic is_special(input f64_t f);
      return f.exp == EXP_W'(EXP_MAX);
   endfunction

   function automatic logic is_zero(input f64_t f);
      return (f.exp == '0) && (f.frac == '0);
   endfunction

endpackage

`default_nettype wire

// File: rtl/f64_double_step.sv
// ============================================================================
// Module : f64_double_step
// Brief  : Combinational exact x2 of a finite binary64 value, flags overflow.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module f64_double_step
   import float_pkg::*;
(
   input  f64_t in_i,
   output f64_t out_o,
   output logic ovf_o
);

   logic [EXP_W+FRAC_W-1:0] w_mag;

   always_comb begin
      out_o = in_i;
      ovf_o = 1'b0;
      w_mag = {in_i.exp, in_i.frac};
      if (in_i.exp == '0) begin
         // Subnormal: shifting the whole magnitude lets frac[51] carry into exp[0].
         w_mag      = {in_i.exp, in_i.frac} << 1;
         out_o.exp  = w_mag[EXP_W+FRAC_W-1:FRAC_W];
         out_o.frac = w_mag[FRAC_W-1:0];
      end else begin
         out_o.exp = in_i.exp + 1'b1;
         if (in_i.exp == EXP_W'(EXP_MAX - 1)) begin
            out_o.frac = '0;
            ovf_o      = 1'b1;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/f64_doubler.sv
// ============================================================================
// Module : f64_doubler
// Brief  : Repeated exact doubling of a binary64 value with step counting.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module f64_doubler
   import float_pkg::*;
#(
   parameter int MAX_STEPS = 2100,
   parameter int CNT_W     = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_valid,
   output logic             start_ready,
   input  logic [63:0]      start_value,
   input  logic             step_en,
   output logic [63:0]      value,
   output logic             value_valid,
   output logic [CNT_W-1:0] step_count,
   output logic             done,
   output logic [2:0]       done_reason
);

   if (MAX_STEPS < 1 || (CNT_W < 64 && 64'(MAX_STEPS) >= (64'd1 << CNT_W))) begin : g_cnt_bad
      $error("f64_doubler: MAX_STEPS must lie in [1, 2**CNT_W)");
   end

   state_t         state_q, state_d;
   f64_t           value_q, value_d;
   logic           valid_q, valid_d;
   logic [CNT_W-1:0] count_q, count_d;
   done_reason_t   reason_q, reason_d;

   f64_t           w_step;
   logic           w_ovf;
   logic [CNT_W-1:0] w_cnt_inc;
   f64_t           w_start;

   assign w_start   = f64_t'(start_value);
   assign w_cnt_inc = count_q + 1'b1;

   f64_double_step u_step (
      .in_i  (value_q),
      .out_o (w_step),
      .ovf_o (w_ovf)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         value_q  <= '0;
         valid_q  <= 1'b0;
         count_q  <= '0;
         reason_q <= DR_NONE;
      end else begin
         state_q  <= state_d;
         value_q  <= value_d;
         valid_q  <= valid_d;
         count_q  <= count_d;
         reason_q <= reason_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      value_d  = value_q;
      valid_d  = 1'b0;
      count_d  = count_q;
      reason_d = reason_q;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start_valid) begin
               value_d  = w_start;
               count_d  = '0;
               reason_d = DR_NONE;
               if (is_special(w_start)) begin
                  state_d  = ST_DONE;
                  reason_d = DR_SPECIAL;
               end else if (is_zero(w_start)) begin
                  state_d  = ST_DONE;
                  reason_d = DR_ZERO;
               end else begin
                  state_d  = ST_RUN;
               end
            end
         end
         ST_RUN: begin
            if (step_en) begin
               value_d = w_step;
               count_d = w_cnt_inc;
               valid_d = 1'b1;
               // Overflow takes priority over the step limit on the same step.
               if (w_ovf) begin
                  state_d  = ST_DONE;
                  reason_d = DR_OVERFLOW;
               end else if (w_cnt_inc == CNT_W'(MAX_STEPS)) begin
                  state_d  = ST_DONE;
                  reason_d = DR_LIMIT;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign start_ready = (state_q != ST_RUN);
   assign value       = value_q;
   assign value_valid = valid_q;
   assign step_count  = count_q;
   assign done        = (state_q == ST_DONE);
   assign done_reason = reason_q;

endmodule

`default_nettype wire

// File: tb/tb_f64_doubler.sv
// ============================================================================
// Module : tb_f64_doubler
// Brief  : Self-checking bench; reference doubling via real arithmetic.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_f64_doubler;

   localparam logic [63:0] C_ONE  = 64'h3FF0000000000000;
   localparam logic [63:0] C_MSUB = 64'h0000000000000001;
   localparam logic [63:0] C_MHLF = 64'hBFE0000000000000;
   localparam logic [63:0] C_NAN  = 64'h7FF8000000000000;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   // Instance A: default limit; instance B: limit of 10.
   logic        a_sv = 0, a_se = 0, a_rdy, a_vv, a_done;
   logic [63:0] a_sval = '0, a_val, a_cnt;
   logic [2:0]  a_r;
   logic        b_sv = 0, b_se = 0, b_rdy, b_vv, b_done;
   logic [63:0] b_sval = '0, b_val, b_cnt;
   logic [2:0]  b_r;

   f64_doubler u_a (
      .clk(clk), .rst(rst), .start_valid(a_sv), .start_ready(a_rdy),
      .start_value(a_sval), .step_en(a_se), .value(a_val), .value_valid(a_vv),
      .step_count(a_cnt), .done(a_done), .done_reason(a_r));

   f64_doubler #(.MAX_STEPS(10), .CNT_W(64)) u_b (
      .clk(clk), .rst(rst), .start_valid(b_sv), .start_ready(b_rdy),
      .start_value(b_sval), .step_en(b_se), .value(b_val), .value_valid(b_vv),
      .step_count(b_cnt), .done(b_done), .done_reason(b_r));

   int n_total = 0, n_pass = 0, b_pulses = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
   endtask

   // ---- reference model: phase 0 idle, 1 run, 2 done ----
   typedef struct packed {
      logic [1:0]  ph;
      logic [63:0] v;
      logic [63:0] c;
      logic        vv;
      logic [2:0]  r;
   } m_t;

   function automatic logic [63:0] dbl(input logic [63:0] v);
      return $realtobits($bitstoreal(v) * 2.0);
   endfunction

   function automatic m_t nxt(input m_t m, input logic sv, input logic [63:0] sval,
                              input logic se, input int maxs);
      m_t n = m;
      n.vv = 1'b0;
      if (m.ph != 2'd1) begin
         if (sv) begin
            n.v = sval; n.c = 0; n.r = 0; n.ph = 2'd1;
            if (sval[62:52] == 11'h7FF)  begin n.ph = 2'd2; n.r = 3'd2; end
            else if (sval[62:0] == '0)   begin n.ph = 2'd2; n.r = 3'd3; end
         end
      end else if (se) begin
         n.v  = dbl(m.v);
         n.c  = m.c + 1;
         n.vv = 1'b1;
         if (n.v[62:52] == 11'h7FF)   begin n.ph = 2'd2; n.r = 3'd1; end
         else if (n.c == 64'(maxs))   begin n.ph = 2'd2; n.r = 3'd4; end
      end
      return n;
   endfunction

   m_t m_a = '0, m_b = '0;

   initial forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
         m_a = '0; m_b = '0;
      end else begin
         m_a = nxt(m_a, a_sv, a_sval, a_se, 2100);
         m_b = nxt(m_b, b_sv, b_sval, b_se, 10);
      end
   end

   // ---- per-cycle compare and capture of stepped values ----
   logic [63:0] dut_seen[int];
   logic [63:0] mdl_seen[int];

   task automatic cmp(input string t, input m_t m, input logic [63:0] v, input logic vv,
                      input logic [63:0] c, input logic d, input logic [2:0] r, input logic rdy);
      chk({t, ".value"}, v, m.v);
      chk({t, ".value_valid"}, 64'(vv), 64'(m.vv));
      chk({t, ".step_count"}, c, m.c);
      chk({t, ".done"}, 64'(d), 64'(m.ph == 2'd2));
      chk({t, ".done_reason"}, 64'(r), 64'(m.r));
      chk({t, ".start_ready"}, 64'(rdy), 64'(m.ph != 2'd1));
   endtask

   initial forever begin
      @(negedge clk);
      if (!rst) begin
         cmp("A", m_a, a_val, a_vv, a_cnt, a_done, a_r, a_rdy);
         cmp("B", m_b, b_val, b_vv, b_cnt, b_done, b_r, b_rdy);
         if (a_vv)   dut_seen[int'(a_cnt)] = a_val;
         if (m_a.vv) mdl_seen[int'(m_a.c)] = m_a.v;
         if (b_vv)   b_pulses++;
      end
   end

   task automatic lit(input string nm, input int step, input logic [63:0] exp);
      n_total++;
      if (!dut_seen.exists(step)) $display("FAIL %s: DUT never produced step %0d", nm, step);
      else if (dut_seen[step] === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", nm, dut_seen[step], exp);
      n_total++;
      if (mdl_seen.exists(step) && mdl_seen[step] === exp) n_pass++;
      else $display("FAIL %s.model: model disagrees with %h", nm, exp);
   endtask

   task automatic load_a(input logic [63:0] v, input logic se);
      @(posedge clk); #2;
      dut_seen.delete(); mdl_seen.delete();
      a_sv = 1'b1; a_sval = v; a_se = se;
      @(posedge clk); #2;
      a_sv = 1'b0;
   endtask

   task automatic wait_a(input int budget);
      for (int i = 0; i < budget && !a_done; i++) @(negedge clk);
      if (!a_done) begin
         n_total++;
         $display("FAIL wait_done: done=%0b after %0d cycles, expected 1", a_done, budget);
      end
   endtask

   task automatic wait_cnt_a(input logic [63:0] n, input int budget);
      for (int i = 0; i < budget && a_cnt != n; i++) @(negedge clk);
      if (a_cnt != n) begin
         n_total++;
         $display("FAIL wait_count: step_count=%0d, expected %0d", a_cnt, n);
      end
   endtask

   initial begin
      #1 rst = 1'b1;
      #1;
      chk("reset.value", a_val, 64'd0);
      chk("reset.count", a_cnt, 64'd0);
      chk("reset.ready", 64'(a_rdy), 64'd1);
      chk("reset.done", {61'd0, a_r} | 64'(a_done) | 64'(a_vv), 64'd0);
      repeat (2) @(posedge clk);
      #2 rst = 1'b0;

      // 1.0 doubled to +inf
      load_a(C_ONE, 1'b1);
      wait_a(1100);
      lit("one.step1", 1, 64'h4000000000000000);
      lit("one.step1024", 1024, 64'h7FF0000000000000);
      chk("one.count", a_cnt, 64'd1024);
      chk("one.reason", 64'(a_r), 64'd1);

      // smallest subnormal, 2098 steps to +inf, directly from DONE
      load_a(C_MSUB, 1'b1);
      wait_a(2200);
      lit("sub.step1", 1, 64'h0000000000000002);
      lit("sub.step52", 52, 64'h0010000000000000);
      chk("sub.count", a_cnt, 64'd2098);
      chk("sub.reason", 64'(a_r), 64'd1);

      // -0.5 to -inf
      load_a(C_MHLF, 1'b1);
      wait_a(1100);
      lit("neg.step1", 1, 64'hBFF0000000000000);
      lit("neg.step1025", 1025, 64'hFFF0000000000000);
      chk("neg.reason", 64'(a_r), 64'd1);

      // +0 then NaN
      load_a(64'd0, 1'b1);
      chk("zero.done", 64'(a_done), 64'd1);
      chk("zero.reason", 64'(a_r), 64'd3);
      chk("zero.count", a_cnt, 64'd0);
      chk("zero.vv", 64'(a_vv), 64'd0);
      @(posedge clk); #2;
      load_a(C_NAN, 1'b1);
      chk("nan.reason", 64'(a_r), 64'd2);
      chk("nan.value", a_val, C_NAN);
      @(posedge clk); #2;
      chk("nan.hold", a_val, C_NAN);

      // start ignored during RUN, then async reset mid-run
      load_a(C_ONE, 1'b1);
      wait_cnt_a(64'd3, 20);
      a_sv = 1'b1; a_sval = 64'd0;
      @(posedge clk); #2;
      a_sv = 1'b0;
      wait_cnt_a(64'd5, 20);
      lit("ign.step4", 4, 64'h4030000000000000);
      #1 rst = 1'b1;
      #1;
      chk("arst.value", a_val, 64'd0);
      chk("arst.count", a_cnt, 64'd0);
      chk("arst.ready", 64'(a_rdy), 64'd1);
      @(posedge clk); #2;
      rst = 1'b0; a_se = 1'b0;

      // limit of 10 with step_en toggling
      @(posedge clk); #2;
      b_pulses = 0;
      b_sv = 1'b1; b_sval = C_ONE; b_se = 1'b0;
      @(posedge clk); #2;
      b_sv = 1'b0;
      for (int i = 0; i < 40 && !b_done; i++) begin
         @(posedge clk); #2;
         b_se = ~b_se;
      end
      @(negedge clk);
      chk("lim.done", 64'(b_done), 64'd1);
      chk("lim.value", b_val, 64'h4090000000000000);
      chk("lim.count", b_cnt, 64'd10);
      chk("lim.reason", 64'(b_r), 64'd4);
      chk("lim.pulses", 64'(b_pulses), 64'd10);

      repeat (3) @(posedge clk);
      #1;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

`default_nettype wire
